// File: rtl/rgen_address_decoder_array.sv
// -----------------------------------------------------------------------------
// rgen_address_decoder_array
//
// Registered multi-register address decoder with a command/response handshake.
// One host command is decoded against NUM_REGISTERS address ranges. Each range
// has its own read/write rights and an optional shadow index. A hit with the
// right direction drives a registered one-hot select into the register array
// until the register reports done. Every other outcome is answered directly
// with an error status.
//
// Optional feature (compile-time macro RGEN_DECODER_TIMEOUT_EN):
//   An ACCESS watchdog. If the register does not finish within TIMEOUT_CYCLES
//   cycles, the access is abandoned with status TIMEOUT (11). When the macro
//   is undefined, ACCESS waits indefinitely and TIMEOUT is never produced.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_command_valid     host command valid
//   o_command_ready     high only in IDLE
//   i_read, i_write     command direction (exactly one must be set)
//   i_address           command address
//   i_shadow_index      command shadow index
//   o_select            registered one-hot register select
//   o_read, o_write     latched direction, valid while o_select != 0
//   i_register_done     selected register finished (used only in ACCESS)
//   o_response_valid    response valid
//   o_response_status   00 OKAY, 01 ACCESS_ERROR, 10 DECODE_ERROR, 11 TIMEOUT
//   i_response_ready    host accepts the response
// -----------------------------------------------------------------------------
module rgen_address_decoder_array #(
  parameter int NUM_REGISTERS      = 4,
  parameter int ADDRESS_WIDTH      = 16,
  parameter logic [NUM_REGISTERS*ADDRESS_WIDTH-1:0] START_ADDRESSES = '0,
  parameter logic [NUM_REGISTERS*ADDRESS_WIDTH-1:0] END_ADDRESSES   = '0,
  parameter logic [NUM_REGISTERS-1:0] READABLE = '1,
  parameter logic [NUM_REGISTERS-1:0] WRITABLE = '1,
  parameter int SHADOW_INDEX_WIDTH = 1,
  parameter logic [NUM_REGISTERS-1:0] USE_SHADOW_INDEX = '0,
  parameter logic [NUM_REGISTERS*SHADOW_INDEX_WIDTH-1:0] SHADOW_INDEX_VALUES = '0,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_command_valid,
  output logic                          o_command_ready,
  input  logic                          i_read,
  input  logic                          i_write,
  input  logic [ADDRESS_WIDTH-1:0]      i_address,
  input  logic [SHADOW_INDEX_WIDTH-1:0] i_shadow_index,
  output logic [NUM_REGISTERS-1:0]      o_select,
  output logic                          o_read,
  output logic                          o_write,
  input  logic                          i_register_done,
  output logic                          o_response_valid,
  output logic [1:0]                    o_response_status,
  input  logic                          i_response_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OKAY         = 2'b00,
    STATUS_ACCESS_ERROR = 2'b01,
    STATUS_DECODE_ERROR = 2'b10,
    STATUS_TIMEOUT      = 2'b11
  } status_e;

  state_e                   state, state_next;
  logic [NUM_REGISTERS-1:0] select_q, select_next;
  logic                     read_q, read_next;
  logic                     write_q, write_next;
  logic                     valid_q, valid_next;
  status_e                  status_q, status_next;

  logic [NUM_REGISTERS-1:0] hit_vec;
  logic [NUM_REGISTERS-1:0] win_onehot;
  logic                     hit_found;
  logic                     permit_read;
  logic                     permit_write;

`ifdef RGEN_DECODER_TIMEOUT_EN
  localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);
  logic [CountWidth-1:0] count_q, count_next;
`endif

  // Per-register hit. Reserved registers (neither readable nor writable) are
  // masked out so they decode as unmapped.
  always_comb begin
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      logic [ADDRESS_WIDTH-1:0]      start_addr;
      logic [ADDRESS_WIDTH-1:0]      end_addr;
      logic [SHADOW_INDEX_WIDTH-1:0] want_index;
      start_addr = START_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end_addr   = END_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      want_index = SHADOW_INDEX_VALUES[i*SHADOW_INDEX_WIDTH +: SHADOW_INDEX_WIDTH];
      hit_vec[i] = (i_address >= start_addr) && (i_address <= end_addr)
                && (!USE_SHADOW_INDEX[i] || (i_shadow_index == want_index))
                && (READABLE[i] || WRITABLE[i]);
    end
  end

  // Lowest index wins: isolate the least significant set bit.
  assign win_onehot   = hit_vec & (~hit_vec + NUM_REGISTERS'(1));
  assign hit_found    = |hit_vec;
  assign permit_read  = |(win_onehot & READABLE);
  assign permit_write = |(win_onehot & WRITABLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    select_next = select_q;
    read_next   = read_q;
    write_next  = write_q;
    valid_next  = valid_q;
    status_next = status_q;
`ifdef RGEN_DECODER_TIMEOUT_EN
    count_next  = count_q;
`endif

    case (state)
      IDLE: begin
        if (i_command_valid) begin
          if (i_read == i_write) begin
            state_next  = RESPOND;
            valid_next  = 1'b1;
            status_next = STATUS_ACCESS_ERROR;
          end else if (!hit_found) begin
            state_next  = RESPOND;
            valid_next  = 1'b1;
            status_next = STATUS_DECODE_ERROR;
          end else if ((i_read && permit_read) || (i_write && permit_write)) begin
            state_next  = ACCESS;
            select_next = win_onehot;
            read_next   = i_read;
            write_next  = i_write;
`ifdef RGEN_DECODER_TIMEOUT_EN
            count_next  = '0;
`endif
          end else begin
            state_next  = RESPOND;
            valid_next  = 1'b1;
            status_next = STATUS_ACCESS_ERROR;
          end
        end
      end

      ACCESS: begin
        // Done is checked first so it wins over a same-cycle timeout.
        if (i_register_done) begin
          state_next  = RESPOND;
          select_next = '0;
          read_next   = 1'b0;
          write_next  = 1'b0;
          valid_next  = 1'b1;
          status_next = STATUS_OKAY;
`ifdef RGEN_DECODER_TIMEOUT_EN
        end else if (count_q == CountWidth'(TIMEOUT_CYCLES - 1)) begin
          state_next  = RESPOND;
          select_next = '0;
          read_next   = 1'b0;
          write_next  = 1'b0;
          valid_next  = 1'b1;
          status_next = STATUS_TIMEOUT;
        end else begin
          count_next  = count_q + CountWidth'(1);
`endif
        end
      end

      RESPOND: begin
        if (i_response_ready) begin
          state_next  = IDLE;
          valid_next  = 1'b0;
          status_next = STATUS_OKAY;
        end
      end

      default: begin
        state_next  = IDLE;
        select_next = '0;
        read_next   = 1'b0;
        write_next  = 1'b0;
        valid_next  = 1'b0;
        status_next = STATUS_OKAY;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      select_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      valid_q  <= 1'b0;
      status_q <= STATUS_OKAY;
`ifdef RGEN_DECODER_TIMEOUT_EN
      count_q  <= '0;
`endif
    end else begin
      state    <= state_next;
      select_q <= select_next;
      read_q   <= read_next;
      write_q  <= write_next;
      valid_q  <= valid_next;
      status_q <= status_next;
`ifdef RGEN_DECODER_TIMEOUT_EN
      count_q  <= count_next;
`endif
    end
  end

  assign o_command_ready   = (state == IDLE);
  assign o_select          = select_q;
  assign o_read            = read_q;
  assign o_write           = write_q;
  assign o_response_valid  = valid_q;
  assign o_response_status = status_q;

endmodule

// File: tb/tb_rgen_address_decoder_array.sv
// -----------------------------------------------------------------------------
// tb_rgen_address_decoder_array
//
// Self-checking bench for rgen_address_decoder_array. Memory map:
//   reg0 0x00        R/W
//   reg1 0x04        read-only
//   reg2 0x08..0x0F  R/W
//   reg3 0x10        R/W, shadow index 2
//   reg4 0x30        reserved (neither readable nor writable)
// Expected response statuses go into a queue when a command is driven and are
// popped when the DUT raises o_response_valid.
// -----------------------------------------------------------------------------
module tb_rgen_address_decoder_array;

  localparam int NR = 5;
  localparam int AW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_command_valid = 1'b0;
  logic          o_command_ready;
  logic          i_read = 1'b0;
  logic          i_write = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [SW-1:0] i_shadow_index = '0;
  logic [NR-1:0] o_select;
  logic          o_read;
  logic          o_write;
  logic          i_register_done = 1'b0;
  logic          o_response_valid;
  logic [1:0]    o_response_status;
  logic          i_response_ready = 1'b0;

  rgen_address_decoder_array #(
    .NUM_REGISTERS      (NR),
    .ADDRESS_WIDTH      (AW),
    .START_ADDRESSES    ({16'h0030, 16'h0010, 16'h0008, 16'h0004, 16'h0000}),
    .END_ADDRESSES      ({16'h0030, 16'h0010, 16'h000F, 16'h0004, 16'h0000}),
    .READABLE           (5'b01111),
    .WRITABLE           (5'b01101),
    .SHADOW_INDEX_WIDTH (SW),
    .USE_SHADOW_INDEX   (5'b01000),
    .SHADOW_INDEX_VALUES({2'd0, 2'd2, 2'd0, 2'd0, 2'd0}),
    .TIMEOUT_CYCLES     (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_command_valid   (i_command_valid),
    .o_command_ready   (o_command_ready),
    .i_read            (i_read),
    .i_write           (i_write),
    .i_address         (i_address),
    .i_shadow_index    (i_shadow_index),
    .o_select          (o_select),
    .o_read            (o_read),
    .o_write           (o_write),
    .i_register_done   (i_register_done),
    .o_response_valid  (o_response_valid),
    .o_response_status (o_response_status),
    .i_response_ready  (i_response_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [SW-1:0] idx;
    int            done_delay;   // ACCESS cycles before done; -1 = never
    int            ready_delay;  // cycles the response is held before ready
    logic [NR-1:0] sel;          // expected select; 0 = error response
    logic [1:0]    status;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_response(input int ready_delay, input logic [1:0] status);
    logic [1:0] want;
    if (!o_response_valid) begin
      check("response_present", o_response_valid, 1'b1);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      check("response_status", o_response_status, want);
    end
    check("cmd_ready_in_respond", o_command_ready, 1'b0);
    repeat (ready_delay) begin
      @(negedge clk);
      check("hold_valid", o_response_valid, 1'b1);
      check("hold_status", o_response_status, status);
      check("hold_cmd_ready", o_command_ready, 1'b0);
    end
    i_response_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_response_ready = 1'b0;
    check("valid_after_ready", o_response_valid, 1'b0);
    check("cmd_ready_after_ready", o_command_ready, 1'b1);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    @(negedge clk);
    check("cmd_ready_idle", o_command_ready, 1'b1);
    i_command_valid = 1'b1;
    i_read          = v.rd;
    i_write         = v.wr;
    i_address       = v.addr;
    i_shadow_index  = v.idx;
    exp_q.push_back(v.status);
    @(posedge clk);
    @(negedge clk);
    i_command_valid = 1'b0;
    i_read          = 1'b0;
    i_write         = 1'b0;
    if (v.sel != '0) begin
      check("select_n1", o_select, v.sel);
      check("read_qual", o_read, v.rd);
      check("write_qual", o_write, v.wr);
      check("no_early_resp", o_response_valid, 1'b0);
      if (v.done_delay >= 0) begin
        repeat (v.done_delay) begin
          @(negedge clk);
          check("select_stable", o_select, v.sel);
        end
        i_register_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_register_done = 1'b0;
        check("select_clear", o_select, '0);
        check("quals_clear", {o_read, o_write}, 2'b00);
      end else begin
        n = 0;
        while (!o_response_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("timeout_latency", n, 4);
        check("select_clear_to", o_select, '0);
      end
    end else begin
      check("err_select_zero", o_select, '0);
      check("err_resp_n1", o_response_valid, 1'b1);
    end
    finish_response(v.ready_delay, v.status);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 1'b0, 16'h000A, 2'd0, 3, 0, 5'b00100, 2'b00});
    vecs.push_back('{1'b0, 1'b1, 16'h0004, 2'd0, 0, 0, 5'b00000, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 16'h0004, 2'd0, 0, 0, 5'b00010, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 16'h0020, 2'd0, 0, 0, 5'b00000, 2'b10});
    vecs.push_back('{1'b1, 1'b0, 16'h0030, 2'd0, 0, 0, 5'b00000, 2'b10});
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 2'd2, 1, 0, 5'b01000, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 2'd1, 0, 0, 5'b00000, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 16'h0010, 2'd2, 0, 0, 5'b00000, 2'b01});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 2'd0, 0, 0, 5'b00000, 2'b01});
    vecs.push_back('{1'b0, 1'b1, 16'h000F, 2'd0, 2, 5, 5'b00100, 2'b00});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 2'd0, 0, 0, 5'b00001, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 16'h0007, 2'd0, 0, 0, 5'b00000, 2'b10});
    vecs.push_back('{1'b1, 1'b0, 16'h0008, 2'd0, 0, 0, 5'b00100, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 16'hFFFF, 2'd3, 0, 0, 5'b00000, 2'b10});
`ifdef RGEN_DECODER_TIMEOUT_EN
    // Never done: TIMEOUT four cycles after ACCESS entry.
    vecs.push_back('{1'b1, 1'b0, 16'h000A, 2'd0, -1, 0, 5'b00100, 2'b11});
    // Done on the expiry cycle: done wins.
    vecs.push_back('{1'b0, 1'b1, 16'h0010, 2'd2, 3, 0, 5'b01000, 2'b00});
`endif

    // Reset state.
    #12;
    check("rst_select", o_select, '0);
    check("rst_quals", {o_read, o_write}, 2'b00);
    check("rst_valid", o_response_valid, 1'b0);
    check("rst_status", o_response_status, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", o_command_ready, 1'b1);

    foreach (vecs[k]) run_txn(vecs[k]);

`ifndef RGEN_DECODER_TIMEOUT_EN
    // Without the watchdog, ACCESS waits indefinitely.
    begin
      int early;
      early = 0;
      @(negedge clk);
      i_command_valid = 1'b1;
      i_read          = 1'b1;
      i_address       = 16'h000A;
      exp_q.push_back(2'b00);
      @(posedge clk);
      @(negedge clk);
      i_command_valid = 1'b0;
      i_read          = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (o_response_valid || o_select != 5'b00100) early++;
      end
      check("no_timeout_100", early, 0);
      i_register_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_register_done = 1'b0;
      finish_response(0, 2'b00);
    end
`endif

    // Reset during ACCESS drops the command immediately, with no response.
    @(negedge clk);
    i_command_valid = 1'b1;
    i_read          = 1'b1;
    i_address       = 16'h0009;
    @(posedge clk);
    @(negedge clk);
    i_command_valid = 1'b0;
    i_read          = 1'b0;
    check("pre_reset_select", o_select, 5'b00100);
    #2 rst_n = 1'b0;
    #1;
    check("async_select", o_select, '0);
    check("async_quals", {o_read, o_write}, 2'b00);
    check("async_valid", o_response_valid, 1'b0);
    check("async_cmd_ready", o_command_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    i_register_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_register_done = 1'b0;
    check("dropped_no_resp", o_response_valid, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
